// File: rtl/flex_crc_so.sv
// flex_crc_so: serial CRC generator and serializer for the transmit path.
// Folds one payload bit per shift_enable cycle into a CRC_WIDTH-bit remainder,
// then shifts out the complemented remainder MSB first on crc_send.
// Optional feature macro: CRC_STALL_EN adds a tx_stall input that freezes the
// serializer so the bit-stuffer can insert a stuff bit.
// CRC_WIDTH must be in the range 2..16 (POLY and INIT are 16-bit values).
module flex_crc_so #(
  parameter int          CRC_WIDTH = 16,
  parameter logic [15:0] POLY      = 16'h8005,
  parameter logic [15:0] INIT      = 16'hFFFF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic shift_enable,
  input  logic data_in,
  input  logic crc_send,
`ifdef CRC_STALL_EN
  input  logic tx_stall,
`endif
  output logic crc_out,
  output logic crc_active,
  output logic crc_done,
  output logic crc_busy
);

  localparam int CNT_W = (CRC_WIDTH > 2) ? $clog2(CRC_WIDTH) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CRC_WIDTH - 1);
  localparam logic [CRC_WIDTH-1:0] POLY_W   = POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] INIT_W   = INIT[CRC_WIDTH-1:0];

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state;
  logic [CRC_WIDTH-1:0] crc_r;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CRC_WIDTH-1:0] fold_r;
  logic [CRC_WIDTH-1:0] acc_r;
  logic [CRC_WIDTH-1:0] shl_r;
  logic                 stall;

  // One LFSR step of the serial CRC: feedback is the incoming bit XOR the MSB.
  function automatic logic [CRC_WIDTH-1:0] crc_fold(input logic [CRC_WIDTH-1:0] r,
                                                    input logic                 b);
    logic fb;
    fb = b ^ r[CRC_WIDTH-1];
    return {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY_W : '0);
  endfunction

`ifdef CRC_STALL_EN
  assign stall = tx_stall;
`else
  assign stall = 1'b0;
`endif

  // Candidate remainders: folded by the current bit, and shifted for serializing.
  always_comb begin
    fold_r = crc_fold(crc_r, data_in);
    acc_r  = shift_enable ? fold_r : crc_r;
    shl_r  = {crc_r[CRC_WIDTH-2:0], 1'b0};
  end

  // Control FSM, remainder and registered serial outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      crc_r      <= INIT_W;
      bit_cnt    <= '0;
      crc_out    <= 1'b1;
      crc_active <= 1'b0;
      crc_done   <= 1'b0;
      crc_busy   <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      crc_r      <= INIT_W;
      bit_cnt    <= '0;
      crc_out    <= 1'b1;
      crc_active <= 1'b0;
      crc_done   <= 1'b0;
      crc_busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (crc_send) begin
            // A bit arriving together with the request is folded before sending.
            state      <= ST_SEND;
            crc_r      <= acc_r;
            bit_cnt    <= '0;
            crc_out    <= ~acc_r[CRC_WIDTH-1];
            crc_active <= 1'b1;
            crc_busy   <= 1'b1;
          end else if (shift_enable) begin
            state <= ST_ACCUM;
            crc_r <= fold_r;
          end
        end
        ST_SEND: begin
          if (!stall) begin
            if (bit_cnt == CNT_LAST) begin
              state      <= ST_DONE;
              crc_r      <= INIT_W;
              bit_cnt    <= '0;
              crc_out    <= 1'b1;
              crc_active <= 1'b0;
              crc_busy   <= 1'b0;
              crc_done   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              crc_r   <= shl_r;
              crc_out <= ~shl_r[CRC_WIDTH-1];
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          crc_done <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flex_crc_so.sv
// tb_flex_crc_so: directed-vector bench for flex_crc_so (W=16, POLY 8005, INIT FFFF).
// Define CRC_STALL_EN to also exercise the tx_stall path.
module tb_flex_crc_so;

  logic clk = 1'b0;
  logic n_rst;
  logic clear;
  logic shift_enable;
  logic data_in;
  logic crc_send;
`ifdef CRC_STALL_EN
  logic tx_stall;
`endif
  logic crc_out;
  logic crc_active;
  logic crc_done;
  logic crc_busy;

  int n_vec = 0;
  int n_err = 0;

  flex_crc_so #(.CRC_WIDTH(16), .POLY(16'h8005), .INIT(16'hFFFF)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .shift_enable (shift_enable),
    .data_in      (data_in),
    .crc_send     (crc_send),
`ifdef CRC_STALL_EN
    .tx_stall     (tx_stall),
`endif
    .crc_out      (crc_out),
    .crc_active   (crc_active),
    .crc_done     (crc_done),
    .crc_busy     (crc_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    clear        = 1'b0;
    shift_enable = 1'b0;
    data_in      = 1'b0;
    crc_send     = 1'b0;
`ifdef CRC_STALL_EN
    tx_stall     = 1'b0;
`endif
  endtask

  task automatic fold_bit(input logic b);
    @(negedge clk);
    shift_enable = 1'b1;
    data_in      = b;
    @(negedge clk);
    shift_enable = 1'b0;
    data_in      = 1'b0;
  endtask

  // Request a send (optionally folding a bit in the same cycle), collect 16 bits,
  // then check the DONE cycle and the return to idle.
  task automatic send_collect(input string tag, input logic [15:0] exp,
                              input logic fold_en, input logic fold_b,
                              input logic toggle);
    logic [15:0] got;
    int          bad;
    got = '0;
    bad = 0;
    @(negedge clk);
    crc_send     = 1'b1;
    shift_enable = fold_en;
    data_in      = fold_b;
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      if (crc_active !== 1'b1 || crc_busy !== 1'b1 || crc_done !== 1'b0) bad++;
      got[15-i] = crc_out;
      if (toggle) begin
        shift_enable = i[0];
        data_in      = ~i[1];
        crc_send     = i[0] ^ i[2];
      end
      @(negedge clk);
    end
    idle_inputs();
    check({tag, " bits"}, got, exp);
    check({tag, " active"}, 16'(bad), 16'd0);
    check({tag, " done cyc"}, {12'd0, crc_done, crc_active, crc_out, crc_busy}, 16'b1010);
    @(negedge clk);
    check({tag, " idle"}, {12'd0, crc_done, crc_active, crc_out, crc_busy}, 16'b0010);
  endtask

  initial begin
    int pulses;
    idle_inputs();
    n_rst = 1'b0;
    #12;
    check("reset outs", {12'd0, crc_out, crc_active, crc_done, crc_busy}, 16'b1000);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post reset", {12'd0, crc_out, crc_active, crc_done, crc_busy}, 16'b1000);

    // clear, then empty send: ~FFFF
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    send_collect("empty", 16'h0000, 1'b0, 1'b0, 1'b0);

    // single bit 1: r = FFFE, out = 0001
    fold_bit(1'b1);
    send_collect("bit1", 16'h0001, 1'b0, 1'b0, 1'b0);

    // single bit 0: r = 7FFB, out = 8004
    fold_bit(1'b0);
    send_collect("bit0", 16'h8004, 1'b0, 1'b0, 1'b0);

    // bits 1,1: FFFF -> FFFE -> FFFC, out = 0003
    fold_bit(1'b1);
    fold_bit(1'b1);
    send_collect("bits11", 16'h0003, 1'b0, 1'b0, 1'b0);

    // bit 0 folded in the same cycle as the request
    send_collect("fold+send", 16'h8004, 1'b1, 1'b0, 1'b0);

    // inputs toggling during SEND are ignored; remainder reloads to INIT after
    fold_bit(1'b0);
    send_collect("toggle", 16'h8004, 1'b0, 1'b0, 1'b1);
    send_collect("after toggle", 16'h0000, 1'b0, 1'b0, 1'b0);

    // clear at the 5th send bit
    fold_bit(1'b0);
    @(negedge clk);
    crc_send = 1'b1;
    @(negedge clk);
    crc_send = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear outs", {12'd0, crc_out, crc_active, crc_busy, crc_done}, 16'b1000);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (crc_done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("clear no done", 16'(pulses), 16'd0);
    send_collect("after clear", 16'h0000, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a send
    fold_bit(1'b1);
    @(negedge clk);
    crc_send = 1'b1;
    @(negedge clk);
    crc_send = 1'b0;
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("async rst", {12'd0, crc_out, crc_active, crc_busy, crc_done}, 16'b1000);
    @(negedge clk);
    n_rst = 1'b1;
    send_collect("after rst", 16'h0000, 1'b0, 1'b0, 1'b0);

`ifdef CRC_STALL_EN
    begin
      logic [15:0] got;
      int          nb;
      int          bad;
      got = '0;
      nb  = 0;
      bad = 0;
      fold_bit(1'b0);
      @(negedge clk);
      crc_send = 1'b1;
      @(negedge clk);
      crc_send = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        tx_stall = (c == 3 || c == 4 || c == 12 || c == 13);
        if (crc_active !== 1'b1 || crc_done !== 1'b0) bad++;
        if (!tx_stall && nb < 16) begin
          got[15-nb] = crc_out;
          nb++;
        end
        @(negedge clk);
      end
      tx_stall = 1'b0;
      check("stall bits", got, 16'h8004);
      check("stall count", 16'(nb), 16'd16);
      check("stall active", 16'(bad), 16'd0);
      check("stall done", {12'd0, crc_done, crc_active, crc_out, crc_busy}, 16'b1010);
      @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
